mem_store_unit: RTL and testbench

MEM_STORE_UNIT -- requirements
Module: mem_store_unit

---
 rtl/mem_map_pkg.sv | 13 +
 rtl/store_byte_router.sv | 48 ++++
 rtl/mem_store_unit.sv | 145 ++++++++++++++
 tb/tb_mem_store_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map definitions: store FSM encodings and the SFR window boundary.
package mem_map_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WR_BOT = 2'd1,
      ST_WR_TOP = 2'd2
   } store_state_e;

   localparam logic [15:0] SFR_LIMIT_DEFAULT = 16'h0040;
   localparam int          SFR_ADDR_W        = 6;

endpackage

// File: rtl/store_byte_router.sv
// Steers one byte write to either the SFR port or the data-memory port and reports
// whether that byte write completes this cycle. Idle ports are driven to zero.
module store_byte_router
   import mem_map_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] SFR_LIMIT = ADDR_W'(SFR_LIMIT_DEFAULT)
) (
   input  logic                  byte_valid,
   input  logic [ADDR_W-1:0]     byte_addr,
   input  logic [7:0]            byte_data,
   input  logic                  dmem_ready,
   output logic                  dmem_we,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [7:0]            dmem_wdata,
   output logic                  sfr_we,
   output logic [SFR_ADDR_W-1:0] sfr_addr,
   output logic [7:0]            sfr_wdata,
   output logic                  byte_done
);

   // Address decode and output gating; an SFR write never waits for dmem_ready.
   always_comb begin
      dmem_we    = 1'b0;
      dmem_addr  = {ADDR_W{1'b0}};
      dmem_wdata = 8'h00;
      sfr_we     = 1'b0;
      sfr_addr   = {SFR_ADDR_W{1'b0}};
      sfr_wdata  = 8'h00;
      byte_done  = 1'b0;
      if (byte_valid) begin
         if (byte_addr < SFR_LIMIT) begin
            sfr_we    = 1'b1;
            sfr_addr  = byte_addr[SFR_ADDR_W-1:0];
            sfr_wdata = byte_data;
            byte_done = 1'b1;
         end else begin
            dmem_we    = 1'b1;
            dmem_addr  = byte_addr;
            dmem_wdata = byte_data;
            byte_done  = dmem_ready;
         end
      end else begin
         byte_done = 1'b0;
      end
   end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store unit: captures a narrow or wide store from EX/MEM and emits it as
// one or two little-endian byte writes, stalling the pipeline until the last completes.
module mem_store_unit
   import mem_map_pkg::*;
#(
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] SFR_LIMIT = ADDR_W'(SFR_LIMIT_DEFAULT)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  st_valid,
   input  logic                  st_wide,
   input  logic [ADDR_W-1:0]     st_addr,
   input  logic [7:0]            st_data_top,
   input  logic [7:0]            st_data_bot,
   input  logic                  dmem_ready,
   output logic                  dmem_we,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [7:0]            dmem_wdata,
   output logic                  sfr_we,
   output logic [SFR_ADDR_W-1:0] sfr_addr,
   output logic [7:0]            sfr_wdata,
   output logic                  stall
);

   store_state_e      state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        top_q, top_d;
   logic [7:0]        bot_q, bot_d;
   logic              wide_q, wide_d;

   logic              byte_valid_s;
   logic [ADDR_W-1:0] byte_addr_s;
   logic [7:0]        byte_data_s;
   logic              byte_done_s;
   logic              last_s;
   logic              stall_s;
   logic              accept_s;

   // Select the byte presented this cycle; the top byte lives at addr+1 and wraps.
   always_comb begin
      byte_valid_s = 1'b0;
      byte_addr_s  = {ADDR_W{1'b0}};
      byte_data_s  = 8'h00;
      case (state_q)
         ST_WR_BOT: begin
            byte_valid_s = 1'b1;
            byte_addr_s  = addr_q;
            byte_data_s  = bot_q;
         end
         ST_WR_TOP: begin
            byte_valid_s = 1'b1;
            byte_addr_s  = addr_q + ADDR_W'(1'b1);
            byte_data_s  = top_q;
         end
         default: begin
            byte_valid_s = 1'b0;
         end
      endcase
   end

   store_byte_router #(
      .ADDR_W    (ADDR_W),
      .SFR_LIMIT (SFR_LIMIT)
   ) u_router (
      .byte_valid (byte_valid_s),
      .byte_addr  (byte_addr_s),
      .byte_data  (byte_data_s),
      .dmem_ready (dmem_ready),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .sfr_we     (sfr_we),
      .sfr_addr   (sfr_addr),
      .sfr_wdata  (sfr_wdata),
      .byte_done  (byte_done_s)
   );

   // Releasing stall in the last write cycle lets the next store be accepted on that edge.
   assign last_s   = byte_done_s & ((state_q == ST_WR_TOP) | ((state_q == ST_WR_BOT) & ~wide_q));
   assign stall_s  = (state_q != ST_IDLE) & ~last_s;
   assign accept_s = st_valid & ~stall_s;
   assign stall    = stall_s;

   // Next-state and capture logic.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      top_d   = top_q;
      bot_d   = bot_q;
      wide_d  = wide_q;
      if (accept_s) begin
         addr_d = st_addr;
         top_d  = st_data_top;
         bot_d  = st_data_bot;
         wide_d = st_wide;
      end else begin
         addr_d = addr_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (accept_s) state_d = ST_WR_BOT;
            else          state_d = ST_IDLE;
         end
         ST_WR_BOT: begin
            if (byte_done_s) begin
               if (wide_q)        state_d = ST_WR_TOP;
               else if (accept_s) state_d = ST_WR_BOT;
               else               state_d = ST_IDLE;
            end else begin
               state_d = ST_WR_BOT;
            end
         end
         ST_WR_TOP: begin
            if (byte_done_s) begin
               if (accept_s) state_d = ST_WR_BOT;
               else          state_d = ST_IDLE;
            end else begin
               state_d = ST_WR_TOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured-store registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= {ADDR_W{1'b0}};
         top_q   <= 8'h00;
         bot_q   <= 8'h00;
         wide_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         top_q   <= top_d;
         bot_q   <= bot_d;
         wide_q  <= wide_d;
      end
   end

endmodule

// File: tb/tb_mem_store_unit.sv
// Directed bench for mem_store_unit: a byte-queue model checked every cycle plus
// hand-computed expectations for each scenario.
module tb_mem_store_unit;

   logic        clock;
   logic        reset_n;
   logic        st_valid;
   logic        st_wide;
   logic [15:0] st_addr;
   logic [7:0]  st_data_top;
   logic [7:0]  st_data_bot;
   logic        dmem_ready;
   logic        dmem_we;
   logic [15:0] dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        sfr_we;
   logic [5:0]  sfr_addr;
   logic [7:0]  sfr_wdata;
   logic        stall;

   int checks = 0;
   int errors = 0;

   mem_store_unit dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .st_valid    (st_valid),
      .st_wide     (st_wide),
      .st_addr     (st_addr),
      .st_data_top (st_data_top),
      .st_data_bot (st_data_bot),
      .dmem_ready  (dmem_ready),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .sfr_we      (sfr_we),
      .sfr_addr    (sfr_addr),
      .sfr_wdata   (sfr_wdata),
      .stall       (stall)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a FIFO of pending byte writes {addr, data}; the head is presented each cycle.
   logic [23:0] mq[$];

   always @(negedge clock) begin : model_cmp
      logic [15:0] h_addr;
      logic [7:0]  h_data;
      logic        e_dwe, e_swe, e_stall, e_done;
      logic [15:0] e_daddr;
      logic [7:0]  e_dwd, e_swd;
      logic [5:0]  e_saddr;
      e_dwe = 1'b0; e_swe = 1'b0; e_stall = 1'b0; e_done = 1'b0;
      e_daddr = 16'h0; e_dwd = 8'h0; e_swd = 8'h0; e_saddr = 6'h0;
      if (!reset_n) begin
         mq.delete();
      end else if (mq.size() > 0) begin
         h_addr = mq[0][23:8];
         h_data = mq[0][7:0];
         if (h_addr < 16'h0040) begin
            e_swe = 1'b1; e_saddr = h_addr[5:0]; e_swd = h_data; e_done = 1'b1;
         end else begin
            e_dwe = 1'b1; e_daddr = h_addr; e_dwd = h_data; e_done = dmem_ready;
         end
         e_stall = !(mq.size() == 1 && e_done);
      end
      chk("m_dmem_we", dmem_we, e_dwe);
      chk("m_dmem_addr", dmem_addr, e_daddr);
      chk("m_dmem_wdata", dmem_wdata, e_dwd);
      chk("m_sfr_we", sfr_we, e_swe);
      chk("m_sfr_addr", sfr_addr, e_saddr);
      chk("m_sfr_wdata", sfr_wdata, e_swd);
      chk("m_stall", stall, e_stall);
      if (reset_n) begin
         if (e_done) void'(mq.pop_front());
         if (st_valid && !e_stall) begin
            mq.push_back({st_addr, st_data_bot});
            if (st_wide) mq.push_back({st_addr + 16'd1, st_data_top});
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic v, input logic w, input logic [15:0] a,
                        input logic [7:0] t, input logic [7:0] b);
      st_valid = v; st_wide = w; st_addr = a; st_data_top = t; st_data_bot = b;
   endtask

   task automatic exp_dmem(input string n, input logic [15:0] a, input logic [7:0] d, input logic s);
      chk({n, "_dmem_we"}, dmem_we, 1'b1);
      chk({n, "_sfr_we"}, sfr_we, 1'b0);
      chk({n, "_dmem_addr"}, dmem_addr, a);
      chk({n, "_dmem_wdata"}, dmem_wdata, d);
      chk({n, "_stall"}, stall, s);
   endtask

   task automatic exp_sfr(input string n, input logic [5:0] a, input logic [7:0] d, input logic s);
      chk({n, "_sfr_we"}, sfr_we, 1'b1);
      chk({n, "_dmem_we"}, dmem_we, 1'b0);
      chk({n, "_sfr_addr"}, sfr_addr, a);
      chk({n, "_sfr_wdata"}, sfr_wdata, d);
      chk({n, "_stall"}, stall, s);
   endtask

   task automatic exp_idle(input string n);
      chk({n, "_dmem_we"}, dmem_we, 1'b0);
      chk({n, "_sfr_we"}, sfr_we, 1'b0);
      chk({n, "_dmem_addr"}, dmem_addr, 16'h0000);
      chk({n, "_stall"}, stall, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0;
      dmem_ready = 1'b1;
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock);
      exp_idle("rst");
      step();
      step();
      reset_n = 1'b1;
      @(negedge clock);
      exp_idle("post_rst");

      // Narrow dmem store
      step();
      drive(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("narrow", 16'h1234, 8'hA5, 1'b0);
      step();
      @(negedge clock); exp_idle("narrow_end");

      // Wide store with dmem_ready low for two cycles
      step();
      drive(1'b1, 1'b1, 16'h2000, 8'h12, 8'h34);
      dmem_ready = 1'b0;
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("wait1", 16'h2000, 8'h34, 1'b1);
      step();
      @(negedge clock); exp_dmem("wait2", 16'h2000, 8'h34, 1'b1);
      step();
      dmem_ready = 1'b1;
      @(negedge clock); exp_dmem("bot_go", 16'h2000, 8'h34, 1'b1);
      step();
      @(negedge clock); exp_dmem("top_go", 16'h2001, 8'h12, 1'b0);
      step();
      @(negedge clock); exp_idle("wide_end");

      // SFR/dmem boundary split, SFR byte completes even with dmem_ready low
      step();
      drive(1'b1, 1'b1, 16'h003F, 8'h77, 8'h66);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      dmem_ready = 1'b0;
      @(negedge clock); exp_sfr("bnd_bot", 6'h3F, 8'h66, 1'b1);
      step();
      dmem_ready = 1'b1;
      @(negedge clock); exp_dmem("bnd_top", 16'h0040, 8'h77, 1'b0);

      // Address wrap from FFFF into SFR space
      step();
      drive(1'b1, 1'b1, 16'hFFFF, 8'hBE, 8'hEF);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("wrap_bot", 16'hFFFF, 8'hEF, 1'b1);
      step();
      @(negedge clock); exp_sfr("wrap_top", 6'h00, 8'hBE, 1'b0);

      // Three back-to-back narrow stores
      step();
      drive(1'b1, 1'b0, 16'h3000, 8'h00, 8'h01);
      step();
      drive(1'b1, 1'b0, 16'h3001, 8'h00, 8'h02);
      @(negedge clock); exp_dmem("b2b0", 16'h3000, 8'h01, 1'b0);
      step();
      drive(1'b1, 1'b0, 16'h3002, 8'h00, 8'h03);
      @(negedge clock); exp_dmem("b2b1", 16'h3001, 8'h02, 1'b0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("b2b2", 16'h3002, 8'h03, 1'b0);
      step();
      @(negedge clock); exp_idle("b2b_end");

      // Narrow SFR store
      step();
      drive(1'b1, 1'b0, 16'h0010, 8'h00, 8'h5A);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      dmem_ready = 1'b0;
      @(negedge clock); exp_sfr("sfr_n", 6'h10, 8'h5A, 1'b0);
      step();
      dmem_ready = 1'b1;

      // Inputs changing while stalled are ignored; held request taken as stall drops
      drive(1'b1, 1'b1, 16'h5000, 8'h11, 8'h22);
      step();
      drive(1'b1, 1'b0, 16'h7000, 8'h00, 8'h44);
      @(negedge clock); exp_dmem("hold_bot", 16'h5000, 8'h22, 1'b1);
      step();
      drive(1'b1, 1'b0, 16'h6000, 8'h00, 8'h33);
      @(negedge clock); exp_dmem("hold_top", 16'h5001, 8'h11, 1'b0);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("hold_next", 16'h6000, 8'h33, 1'b0);
      step();
      @(negedge clock); exp_idle("hold_end");

      // Reset during the top-byte write of a wide store
      step();
      drive(1'b1, 1'b1, 16'h4000, 8'hAA, 8'hBB);
      step();
      drive(1'b0, 1'b0, 16'h0000, 8'h00, 8'h00);
      @(negedge clock); exp_dmem("rm_bot", 16'h4000, 8'hBB, 1'b1);
      step();
      exp_dmem("rm_top", 16'h4001, 8'hAA, 1'b0);
      reset_n = 1'b0;
      #1;
      exp_idle("rm_async");
      @(negedge clock); exp_idle("rm_low");
      step();
      reset_n = 1'b1;
      @(negedge clock); exp_idle("rm_rel1");
      step();
      @(negedge clock); exp_idle("rm_rel2");

      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
